sensor_frame_scheduler: RTL and testbench

- Sequences the pixel-sensor state block frame by frame: holds it in reset, releases it to run one full erase/expose/convert/read cycle, and detects completion.
- Supports single-shot and continuous capture, with shadowed configuration applied at frame boundaries.
- Provides readout backpressure gating, an inter-frame gap and a watchdog.
- Sits between the host/config interface and the sensor state block.

---
 rtl/sensor_frame_scheduler_pkg.sv | 22 ++
 rtl/sched_watchdog.sv | 38 +++
 rtl/sensor_frame_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_sensor_frame_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_frame_scheduler_pkg.sv
// Shared types and constants for the sensor frame scheduler.
// Holds the scheduler state enum, default exposure and array height.
package sensor_frame_scheduler_pkg;

  localparam int PIXEL_ARRAY_HEIGHT = 16;
  localparam int ROW_CNT_BITS       = 12;
  localparam int DEFAULT_EXPOSE     = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE,
    ST_GAP,
    ST_ERR
  } sched_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Clearable up-counter with a terminal-count flag.
// The terminal value is an input so one counter serves RUN and GAP.
module sched_watchdog #(
  parameter int W = 13
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear dominates, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == tc_val_i);

endmodule

// File: rtl/sensor_frame_scheduler.sv
// Frame-by-frame sequencer for the pixel sensor state block.
// Optional row-count check: define SENSOR_SCHED_ROW_CHECK_EN.
module sensor_frame_scheduler
  import sensor_frame_scheduler_pkg::*;
#(
  parameter int EXPOSE_BITS      = 8,
  parameter int FRAME_COUNT_BITS = 16,
  parameter int INTER_FRAME_GAP  = 4,
  parameter int WATCHDOG_CYCLES  = 4096
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cfg_we_i,
  input  logic [EXPOSE_BITS-1:0]      cfg_expose_time_i,
  input  logic                        cfg_continuous_i,
  input  logic                        frame_req_i,
  input  logic                        stop_i,
  input  logic                        readout_ready_i,
  input  logic                        sensor_frame_finished_i,
  input  logic                        sensor_new_row_i,
  output logic                        sensor_reset_o,
  output logic [EXPOSE_BITS-1:0]      sensor_expose_time_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic [FRAME_COUNT_BITS-1:0] frame_count_o,
`ifdef SENSOR_SCHED_ROW_CHECK_EN
  output logic                        row_error_o,
`endif
  output logic                        error_o
);

  localparam int CNT_MAX = max_int(WATCHDOG_CYCLES, INTER_FRAME_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GAP_TC  = (INTER_FRAME_GAP > 0) ? INTER_FRAME_GAP - 1 : 0;
  localparam logic [EXPOSE_BITS-1:0] EXP_RST = EXPOSE_BITS'(DEFAULT_EXPOSE);

  sched_state_t                state_q;
  logic                        sensor_reset_q;
  logic [EXPOSE_BITS-1:0]      expose_q;
  logic                        cont_q;
  logic                        busy_q;
  logic                        frame_done_q;
  logic [FRAME_COUNT_BITS-1:0] frame_count_q;
  logic                        error_q;
  logic [EXPOSE_BITS-1:0]      shadow_exp_q;
  logic                        shadow_cont_q;
  logic                        stop_pend_q;
  logic                        req_pend_q;

  logic                        wd_en;
  logic                        wd_clr;
  logic                        wd_tc;
  logic [CNT_W-1:0]            wd_tc_val;
  logic                        go_on;
  logic                        decide;

  // One counter times both the RUN watchdog and the inter-frame gap.
  always_comb begin
    wd_en     = (state_q == ST_RUN) || (state_q == ST_GAP);
    wd_clr    = !wd_en;
    wd_tc_val = CNT_W'(WATCHDOG_CYCLES - 1);
    if (state_q == ST_GAP) begin
      wd_tc_val = CNT_W'(GAP_TC);
    end
  end

  sched_watchdog #(
    .W(CNT_W)
  ) u_wd (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .tc_val_i(wd_tc_val),
    .tc_o    (wd_tc)
  );

  // Continuation decision point after a completed frame.
  always_comb begin
    go_on  = (cont_q && !stop_pend_q) || req_pend_q;
    decide = 1'b0;
    if (state_q == ST_DONE && INTER_FRAME_GAP == 0) begin
      decide = 1'b1;
    end
    if (state_q == ST_GAP && wd_tc) begin
      decide = 1'b1;
    end
  end

  // Shadow configuration, writable in any state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_exp_q  <= EXP_RST;
      shadow_cont_q <= 1'b0;
    end else if (cfg_we_i) begin
      shadow_exp_q  <= cfg_expose_time_i;
      shadow_cont_q <= cfg_continuous_i;
    end
  end

  // Scheduler FSM with registered outputs and pending flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      sensor_reset_q <= 1'b1;
      expose_q       <= EXP_RST;
      cont_q         <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= '0;
      error_q        <= 1'b0;
      stop_pend_q    <= 1'b0;
      req_pend_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cfg_we_i) begin
        error_q <= 1'b0;
      end
      if (state_q != ST_IDLE) begin
        if (stop_i) begin
          stop_pend_q <= 1'b1;
        end else if (frame_req_i) begin
          req_pend_q <= 1'b1;
        end
      end
      unique case (state_q)
        ST_IDLE: begin
          if (frame_req_i) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (readout_ready_i) begin
            state_q        <= ST_RUN;
            sensor_reset_q <= 1'b0;
            expose_q       <= shadow_exp_q;
            cont_q         <= shadow_cont_q;
          end
        end
        ST_RUN: begin
          if (sensor_frame_finished_i) begin
            state_q        <= ST_DONE;
            sensor_reset_q <= 1'b1;
            frame_done_q   <= 1'b1;
            frame_count_q  <= frame_count_q + 1'b1;
          end else if (wd_tc) begin
            state_q        <= ST_ERR;
            sensor_reset_q <= 1'b1;
            error_q        <= 1'b1;
          end
        end
        ST_DONE, ST_GAP: begin
          if (decide) begin
            state_q     <= go_on ? ST_ARM : ST_IDLE;
            busy_q      <= go_on;
            stop_pend_q <= 1'b0;
            req_pend_q  <= 1'b0;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_ERR: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          stop_pend_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SENSOR_SCHED_ROW_CHECK_EN
  logic [ROW_CNT_BITS-1:0] row_cnt_q;
  logic [ROW_CNT_BITS-1:0] rows_seen;
  logic                    row_error_q;

  assign rows_seen = row_cnt_q + ROW_CNT_BITS'(sensor_new_row_i);

  // Row pulses counted per frame; reset while armed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_cnt_q <= '0;
    end else if (state_q == ST_ARM) begin
      row_cnt_q <= '0;
    end else if (state_q == ST_RUN && sensor_new_row_i) begin
      row_cnt_q <= row_cnt_q + 1'b1;
    end
  end

  // Sticky short/long frame flag; a same-cycle set beats the clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_error_q <= 1'b0;
    end else if (state_q == ST_RUN && sensor_frame_finished_i &&
                 rows_seen != ROW_CNT_BITS'(PIXEL_ARRAY_HEIGHT)) begin
      row_error_q <= 1'b1;
    end else if (cfg_we_i) begin
      row_error_q <= 1'b0;
    end
  end

  assign row_error_o = row_error_q;
`else
  logic unused_new_row;
  assign unused_new_row = sensor_new_row_i;
`endif

  assign sensor_reset_o       = sensor_reset_q;
  assign sensor_expose_time_o = expose_q;
  assign busy_o               = busy_q;
  assign frame_done_o         = frame_done_q;
  assign frame_count_o        = frame_count_q;
  assign error_o              = error_q;

endmodule

// File: tb/tb_sensor_frame_scheduler.sv
// Randomized scenario bench for sensor_frame_scheduler.
// Expectations come from a frame-level model of the scheduler rules.
module tb_sensor_frame_scheduler;
  import sensor_frame_scheduler_pkg::*;

  localparam int EB  = 8;
  localparam int CB  = 4;
  localparam int GAP = 4;
  localparam int WD  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [EB-1:0] cfg_exp = '0;
  logic          cfg_cont = 1'b0;
  logic          frame_req = 1'b0;
  logic          stop = 1'b0;
  logic          ready = 1'b1;
  logic          fin = 1'b0;
  logic          new_row = 1'b0;
  logic          sensor_reset;
  logic [EB-1:0] sexp;
  logic          busy;
  logic          fdone;
  logic [CB-1:0] fcount;
  logic          error;
`ifdef SENSOR_SCHED_ROW_CHECK_EN
  logic          row_error;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [CB-1:0] m_count;
  logic [EB-1:0] m_shadow;
  logic [EB-1:0] m_active;
  bit            m_cont;

  sensor_frame_scheduler #(
    .EXPOSE_BITS     (EB),
    .FRAME_COUNT_BITS(CB),
    .INTER_FRAME_GAP (GAP),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk_i                  (clk),
    .reset_i                (rst),
    .cfg_we_i               (cfg_we),
    .cfg_expose_time_i      (cfg_exp),
    .cfg_continuous_i       (cfg_cont),
    .frame_req_i            (frame_req),
    .stop_i                 (stop),
    .readout_ready_i        (ready),
    .sensor_frame_finished_i(fin),
    .sensor_new_row_i       (new_row),
    .sensor_reset_o         (sensor_reset),
    .sensor_expose_time_o   (sexp),
    .busy_o                 (busy),
    .frame_done_o           (fdone),
    .frame_count_o          (fcount),
`ifdef SENSOR_SCHED_ROW_CHECK_EN
    .row_error_o            (row_error),
`endif
    .error_o                (error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic [EB-1:0] e, input bit c);
    cfg_we = 1'b1;
    cfg_exp = e;
    cfg_cont = c;
    tick();
    cfg_we = 1'b0;
    m_shadow = e;
    m_cont = c;
  endtask

  task automatic start_req;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_run(input int budget, output int n, output bit ok);
    n = 0;
    while (sensor_reset === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (sensor_reset === 1'b0);
    if (ok) m_active = m_shadow;
  endtask

  task automatic wait_idle(input int budget, output int n, output bit ok);
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic finish_frame(output logic fd, output logic [CB-1:0] fc);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    fd = fdone;
    fc = fcount;
    m_count = m_count + 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    m_count = '0;
    m_shadow = EB'(DEFAULT_EXPOSE);
    m_cont = 1'b0;
    vectors++; if (sensor_reset !== 1'b1) begin miscompares++; $display("FAIL rst_sreset: got %0d want 1", sensor_reset); end
    vectors++; if (sexp !== m_shadow) begin miscompares++; $display("FAIL rst_expose: got %0d want %0d", sexp, m_shadow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0d want 0", busy); end
    vectors++; if (fdone !== 1'b0) begin miscompares++; $display("FAIL rst_fdone: got %0d want 0", fdone); end
    vectors++; if (fcount !== m_count) begin miscompares++; $display("FAIL rst_count: got %0d want %0d", fcount, m_count); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %0d want 0", error); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_shot;
    int n; bit ok; bit bad; logic fd; logic [CB-1:0] fc;
    pulse_cfg(8'd100, 1'b0);
    ready = 1'b1;
    start_req();
    vectors++; if (busy !== 1'b1 || sensor_reset !== 1'b1) begin miscompares++; $display("FAIL ss_arm: got busy=%0d sreset=%0d want 1 1", busy, sensor_reset); end
    wait_run(10, n, ok);
    vectors++; if (!ok || n != 1) begin miscompares++; $display("FAIL ss_latency: got %0d want 1", n); end
    vectors++; if (sexp !== 8'd100) begin miscompares++; $display("FAIL ss_expose: got %0d want 100", sexp); end
    bad = 1'b0;
    repeat (598) begin
      tick();
      if (sensor_reset !== 1'b0 || fdone !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL ss_run_hold: got glitch want steady run"); end
    finish_frame(fd, fc);
    vectors++; if (fd !== 1'b1 || fc !== m_count) begin miscompares++; $display("FAIL ss_done: got fd=%0d cnt=%0d want 1 %0d", fd, fc, m_count); end
    tick();
    vectors++; if (fdone !== 1'b0) begin miscompares++; $display("FAIL ss_pulse: got %0d want 0", fdone); end
    wait_idle(20, n, ok);
    vectors++; if (!ok || n != GAP) begin miscompares++; $display("FAIL ss_idle: got %0d want %0d", n, GAP); end
    vectors++; if (sensor_reset !== 1'b1 || fcount !== m_count) begin miscompares++; $display("FAIL ss_final: got sreset=%0d cnt=%0d want 1 %0d", sensor_reset, fcount, m_count); end
  endtask

  task automatic test_continuous;
    int n; bit ok; bit bad; int d; logic fd; logic [CB-1:0] fc; logic [CB-1:0] c0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b1);
    c0 = m_count;
    start_req();
    wait_run(10, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL cont_start: got no run want run"); end
    for (int f = 0; f < 3; f++) begin
      vectors++; if (sexp !== m_active) begin miscompares++; $display("FAIL cont_expose: got %0d want %0d", sexp, m_active); end
      d = $urandom_range(5, 40);
      for (int k = 0; k < d; k++) begin
        stop = (f == 2 && k == d / 2);
        tick();
      end
      stop = 1'b0;
      finish_frame(fd, fc);
      vectors++; if (fd !== 1'b1 || fc !== m_count) begin miscompares++; $display("FAIL cont_done: got fd=%0d cnt=%0d want 1 %0d", fd, fc, m_count); end
      if (f < 2) begin
        wait_run(20, n, ok);
        vectors++; if (!ok || n != GAP + 2) begin miscompares++; $display("FAIL cont_gap: got %0d want %0d", n, GAP + 2); end
      end else begin
        wait_idle(20, n, ok);
        vectors++; if (!ok || n != GAP + 1) begin miscompares++; $display("FAIL cont_stop: got %0d want %0d", n, GAP + 1); end
      end
    end
    vectors++; if (fcount !== CB'(c0 + 3)) begin miscompares++; $display("FAIL cont_count: got %0d want %0d", fcount, CB'(c0 + 3)); end
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (sensor_reset !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL cont_quiet: got restart want idle"); end
  endtask

  task automatic test_backpressure_shadow;
    int n; bit ok; bit bad; logic fd; logic [CB-1:0] fc;
    pulse_cfg(8'd100, 1'b0);
    ready = 1'b0;
    start_req();
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (sensor_reset !== 1'b1) bad = 1'b1;
    end
    vectors++; if (bad || busy !== 1'b1) begin miscompares++; $display("FAIL bp_hold: got bad=%0d busy=%0d want 0 1", bad, busy); end
    ready = 1'b1;
    wait_run(5, n, ok);
    vectors++; if (!ok || n != 1) begin miscompares++; $display("FAIL bp_release: got %0d want 1", n); end
    pulse_cfg(8'd20, 1'b0);
    ready = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (sensor_reset !== 1'b0 || sexp !== m_active) bad = 1'b1;
    end
    vectors++; if (bad || sexp !== 8'd100) begin miscompares++; $display("FAIL bp_shadow: got %0d want 100", sexp); end
    ready = 1'b1;
    finish_frame(fd, fc);
    vectors++; if (fd !== 1'b1 || fc !== m_count) begin miscompares++; $display("FAIL bp_done: got fd=%0d cnt=%0d want 1 %0d", fd, fc, m_count); end
    wait_idle(20, n, ok);
    start_req();
    wait_run(5, n, ok);
    vectors++; if (!ok || sexp !== 8'd20) begin miscompares++; $display("FAIL bp_next: got %0d want 20", sexp); end
    repeat ($urandom_range(1, 10)) tick();
    finish_frame(fd, fc);
    wait_idle(20, n, ok);
  endtask

  task automatic test_req_pending;
    int n; bit ok; logic fd; logic [CB-1:0] fc; logic [CB-1:0] c0;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b0);
    c0 = m_count;
    start_req();
    wait_run(5, n, ok);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    finish_frame(fd, fc);
    wait_run(20, n, ok);
    vectors++; if (!ok || n != GAP + 2) begin miscompares++; $display("FAIL rp_second: got %0d want %0d", n, GAP + 2); end
    repeat ($urandom_range(1, 10)) tick();
    finish_frame(fd, fc);
    wait_idle(20, n, ok);
    vectors++; if (!ok || n != GAP + 1) begin miscompares++; $display("FAIL rp_oneDeep: got %0d want %0d", n, GAP + 1); end
    vectors++; if (fcount !== CB'(c0 + 2)) begin miscompares++; $display("FAIL rp_count: got %0d want %0d", fcount, CB'(c0 + 2)); end
  endtask

  task automatic test_collision;
    int n; bit ok; bit bad; logic fd; logic [CB-1:0] fc;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b1);
    start_req();
    wait_run(5, n, ok);
    stop = 1'b1;
    frame_req = 1'b1;
    tick();
    stop = 1'b0;
    frame_req = 1'b0;
    repeat ($urandom_range(1, 20)) tick();
    finish_frame(fd, fc);
    vectors++; if (fd !== 1'b1 || fc !== m_count) begin miscompares++; $display("FAIL col_done: got fd=%0d cnt=%0d want 1 %0d", fd, fc, m_count); end
    wait_idle(20, n, ok);
    vectors++; if (!ok || n != GAP + 1) begin miscompares++; $display("FAIL col_stop: got %0d want %0d", n, GAP + 1); end
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (sensor_reset !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL col_quiet: got restart want idle"); end
  endtask

  task automatic test_watchdog;
    int n; bit ok; bit seen; logic [CB-1:0] c0;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b0);
    c0 = m_count;
    start_req();
    wait_run(5, n, ok);
    n = 1;
    seen = 1'b0;
    while (sensor_reset === 1'b0 && n < WD + 50) begin
      tick();
      if (sensor_reset === 1'b0) n++;
      if (fdone === 1'b1) seen = 1'b1;
    end
    vectors++; if (n != WD) begin miscompares++; $display("FAIL wd_cycles: got %0d want %0d", n, WD); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL wd_error: got %0d want 1", error); end
    vectors++; if (seen || fcount !== c0) begin miscompares++; $display("FAIL wd_nodone: got cnt=%0d want %0d", fcount, c0); end
    tick();
    vectors++; if (busy !== 1'b0 || error !== 1'b1) begin miscompares++; $display("FAIL wd_idle: got busy=%0d err=%0d want 0 1", busy, error); end
    pulse_cfg(m_shadow, 1'b0);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL wd_clear: got %0d want 0", error); end
  endtask

  task automatic test_wrap;
    int n; bit ok; logic fd; logic [CB-1:0] fc;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b1);
    start_req();
    for (int f = 0; f < 18; f++) begin
      wait_run(20, n, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_run: got no run want run"); end
      stop = (f == 17);
      tick();
      stop = 1'b0;
      repeat ($urandom_range(0, 6)) tick();
      finish_frame(fd, fc);
      vectors++; if (fd !== 1'b1 || fc !== m_count) begin miscompares++; $display("FAIL wrap_count: got %0d want %0d", fc, m_count); end
    end
    wait_idle(20, n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_idle: got busy want idle"); end
  endtask

`ifdef SENSOR_SCHED_ROW_CHECK_EN
  task automatic test_row_check;
    int n; bit ok; logic fd; logic [CB-1:0] fc;
    pulse_cfg(EB'($urandom_range(0, 255)), 1'b0);
    start_req();
    wait_run(5, n, ok);
    for (int k = 0; k < PIXEL_ARRAY_HEIGHT - 1; k++) begin
      new_row = 1'b1;
      tick();
      new_row = 1'b0;
      tick();
    end
    finish_frame(fd, fc);
    vectors++; if (fd !== 1'b1 || row_error !== 1'b1) begin miscompares++; $display("FAIL row_short: got fd=%0d rerr=%0d want 1 1", fd, row_error); end
    wait_idle(20, n, ok);
    pulse_cfg(m_shadow, 1'b0);
    vectors++; if (row_error !== 1'b0) begin miscompares++; $display("FAIL row_clear: got %0d want 0", row_error); end
    start_req();
    wait_run(5, n, ok);
    for (int k = 0; k < PIXEL_ARRAY_HEIGHT; k++) begin
      new_row = 1'b1;
      tick();
      new_row = 1'b0;
      tick();
    end
    finish_frame(fd, fc);
    vectors++; if (fd !== 1'b1 || row_error !== 1'b0) begin miscompares++; $display("FAIL row_ok: got fd=%0d rerr=%0d want 1 0", fd, row_error); end
    wait_idle(20, n, ok);
  endtask
`endif

  task automatic test_reset_mid_run;
    int n; bit ok; logic fd; logic [CB-1:0] fc;
    pulse_cfg(8'd77, 1'b1);
    start_req();
    wait_run(5, n, ok);
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    m_count = '0;
    m_shadow = EB'(DEFAULT_EXPOSE);
    m_cont = 1'b0;
    vectors++; if (sensor_reset !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_async: got sreset=%0d busy=%0d want 1 0", sensor_reset, busy); end
    vectors++; if (sexp !== m_shadow || fcount !== m_count || error !== 1'b0) begin miscompares++; $display("FAIL mid_vals: got exp=%0d cnt=%0d want %0d %0d", sexp, fcount, m_shadow, m_count); end
    tick();
    rst = 1'b0;
    tick();
    start_req();
    wait_run(5, n, ok);
    vectors++; if (!ok || sexp !== m_active) begin miscompares++; $display("FAIL mid_shadow: got %0d want %0d", sexp, m_active); end
    repeat ($urandom_range(1, 10)) tick();
    finish_frame(fd, fc);
    vectors++; if (fc !== m_count) begin miscompares++; $display("FAIL mid_count: got %0d want %0d", fc, m_count); end
    wait_idle(20, n, ok);
    vectors++; if (!ok || n != GAP + 1) begin miscompares++; $display("FAIL mid_single: got %0d want %0d", n, GAP + 1); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_backpressure_shadow();
    test_req_pending();
    test_collision();
    test_watchdog();
    test_wrap();
`ifdef SENSOR_SCHED_ROW_CHECK_EN
    test_row_check();
`endif
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
